// File: rtl/input_debouncer.sv
// input_debouncer: synchronizer chain followed by a 4-state stability FSM that turns a raw,
// bouncy level input into a clean, clock-synchronous level with one transition per
// physical press/release.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add a saturating count of rejected
// transitions on port glitch_cnt.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W        = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    output logic                out,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StLow      = 2'b00,
        StWaitHigh = 2'b01,
        StHigh     = 2'b10,
        StWaitLow  = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   out_q;
    logic                   busy_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign out  = out_q;
    assign busy = busy_q;

    // Synchronizer chain: shift the raw input toward s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Stability FSM; out/busy are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLow;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= StHigh;
                            out_q   <= 1'b1;
                        end else begin
                            state_q <= StWaitHigh;
                            cnt_q   <= CNT_ONE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StWaitHigh: begin
                    if (s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                            out_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Candidate rise did not hold long enough: fall back to LOW.
                        state_q <= StLow;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                StHigh: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= StLow;
                            out_q   <= 1'b0;
                        end else begin
                            state_q <= StWaitLow;
                            cnt_q   <= CNT_ONE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StWaitLow: begin
                    if (!s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Candidate fall did not hold long enough: fall back to HIGH.
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q;

    assign abort      = ((state_q == StWaitHigh) && !s) || ((state_q == StWaitLow) && s);
    assign glitch_cnt = glitch_q;

    // Count aborted qualifications, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: a run-length reference model pushes the expected
// out/busy/glitch_cnt for every clock into a scoreboard queue, popped at the following negedge.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int GW   = 2;
`else
    localparam int GW   = 8;
`endif
    localparam int GSAT = (1 << GW) - 1;
    localparam int LAT  = SYNC + DEB - 1;

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic out;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .GLITCH_W        (GW)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .out  (out),
        .busy (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic e_out;
        logic e_busy;
        int   e_glitch;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [SYNC-1:0] m_sync;
    logic            m_out;
    int              m_run;
    int              m_glitch;
    int              rises;
    logic            prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sync   = '0;
        m_out    = 1'b0;
        m_run    = 0;
        m_glitch = 0;
    endtask

    // One clock of the reference: out flips once DEB consecutive samples disagree with it.
    task automatic model_step(input logic v);
        logic s;
        s = m_sync[SYNC-1];
        if (s != m_out) begin
            m_run++;
            if (m_run == DEB) begin
                m_out = s;
                m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < GSAT) m_glitch++;
            m_run = 0;
        end
        m_sync = {m_sync[SYNC-2:0], v};
    endtask

    task automatic push_exp();
        exp_t e;
        e.e_out    = m_out;
        e.e_busy   = (m_run > 0);
        e.e_glitch = m_glitch;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_out"}, {31'd0, out}, {31'd0, e.e_out});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, e.e_busy});
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check({tag, "_glitch"}, 32'(glitch_cnt), e.e_glitch);
`endif
    endtask

    task automatic cycle(input string tag, input logic v);
        in = v;
        model_step(v);
        push_exp();
        @(posedge clk);
        @(negedge clk);
        if (out === 1'b1 && prev_out === 1'b0) rises++;
        prev_out = out;
        compare(tag);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        #1;
        push_exp();
        compare("rst");
        repeat (n) @(negedge clk);
        rst      = 1'b0;
        prev_out = 1'b0;
    endtask

    // Hold 'in' and return the cycle index at which out first equals 'target' (-1 if never).
    task automatic measure(input string tag, input logic v, input logic target, output int lat);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(tag, v);
            if (out === target && lat < 0) lat = i;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        logic v;
        logic [5:0] bounce_a;
        logic [5:0] bounce_b;

        rises = 0;
        in    = 1'b0;
        do_reset(3);

        // Idle low.
        repeat (20) cycle("t1_idle", 1'b0);

        // Short pulse is rejected.
        repeat (2) cycle("t3_glitch", 1'b1);
        repeat (10) cycle("t3_settle", 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t3_glitch_cnt", 32'(glitch_cnt), 1);
`endif
        check("t3_no_rise", rises, 0);

        // Clean rise: out on 6th edge.
        measure("t2_rise", 1'b1, 1'b1, lat);
        check("t2_latency", lat, LAT);

        // Clean fall: same latency.
        measure("t4_fall", 1'b0, 1'b0, lat);
        check("t4_latency", lat, LAT);

        // Bouncy press and release: one out pulse.
        r0       = rises;
        bounce_a = 6'b101101;
        bounce_b = 6'b010010;
        for (int i = 5; i >= 0; i--) cycle("t4_bounce_p", bounce_a[i]);
        repeat (10) cycle("t4_hold_p", 1'b1);
        for (int i = 5; i >= 0; i--) cycle("t4_bounce_r", bounce_b[i]);
        repeat (10) cycle("t4_hold_r", 1'b0);
        check("t4_press_pulses", rises - r0, 1);

        // Reset mid-qualification aborts; full latency afterwards.
        repeat (4) cycle("t5_wait", 1'b1);
        check("t5_busy_mid", {31'd0, busy}, 1);
        do_reset(2);
        measure("t5_after", 1'b1, 1'b1, lat);
        check("t5_latency", lat, LAT);

        // Random bouncy activity with variable hold times.
        for (int i = 0; i < 120; i++) begin
            v = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 7)) cycle("rnd", v);
        end

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // Saturation of the glitch counter.
        in = 1'b0;
        do_reset(2);
        for (int g = 0; g < 5; g++) begin
            repeat (2) cycle("t6_pulse", 1'b1);
            repeat (6) cycle("t6_gap", 1'b0);
        end
        check("t6_glitch_sat", 32'(glitch_cnt), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
